// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and FSM state type for the AES block loader
package aes_pkg;

  localparam int key_words_lp = 8;
  localparam int blk_words_lp = 4;

  typedef enum logic {
    eFILL,
    eFULL
  } loader_state_e;

endpackage

// File: rtl/aes_word_shift_reg.sv
// rtl/aes_word_shift_reg.sv - word-wide shift register with enable; newest word enters the low end
module aes_word_shift_reg #(
  parameter int words_p = 4,
  parameter int width_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       en_i,
  input  logic [width_p-1:0]         data_i,
  output logic [words_p*width_p-1:0] data_o
);

  logic [words_p*width_p-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = {data_q[words_p*width_p-width_p-1:0], data_i};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - assembles a 256-bit key and 128-bit block from a word stream
// and holds them stable for the combinational decryption core until yumi.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int word_width_p = 32
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [word_width_p-1:0]              data_i,
  input  logic                                 key_sel_i,
  input  logic                                 v_i,
  output logic                                 ready_o,
  output logic [key_words_lp*word_width_p-1:0] key_o,
  output logic [blk_words_lp*word_width_p-1:0] ciphertext_o,
  output logic                                 key_loaded_o,
  output logic                                 v_o,
  input  logic                                 yumi_i
);

  loader_state_e state_q, state_d;
  logic [2:0]    key_cnt_q, key_cnt_d;
  logic [1:0]    blk_cnt_q, blk_cnt_d;
  logic          key_loaded_q, key_loaded_d;
  logic          key_acc, blk_acc;

  // In eFULL only key words may enter, and only while no complete key is held,
  // so a block that beats its key cannot deadlock the stream.
  assign ready_o = reset_i & ((state_q == eFILL)
                            | ((state_q == eFULL) & ~key_loaded_q & key_sel_i));
  assign key_acc = v_i & ready_o & key_sel_i;
  assign blk_acc = v_i & ready_o & ~key_sel_i;
  assign v_o          = (state_q == eFULL) & key_loaded_q;
  assign key_loaded_o = key_loaded_q;

  always_comb begin
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    key_loaded_d = key_loaded_q;
    if (key_acc) begin
      key_cnt_d = key_cnt_q + 3'd1;
      if (key_cnt_q == 3'd0) key_loaded_d = 1'b0;
      if (key_cnt_q == 3'(key_words_lp - 1)) key_loaded_d = 1'b1;
    end
    case (state_q)
      eFILL: begin
        if (blk_acc) begin
          blk_cnt_d = blk_cnt_q + 2'd1;
          if (blk_cnt_q == 2'(blk_words_lp - 1)) state_d = eFULL;
        end
      end
      eFULL: begin
        if (yumi_i & v_o) state_d = eFILL;
      end
      default: state_d = eFILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= eFILL;
      key_cnt_q    <= '0;
      blk_cnt_q    <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  aes_word_shift_reg #(.words_p(key_words_lp), .width_p(word_width_p)) u_key_sr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (key_acc),
    .data_i  (data_i),
    .data_o  (key_o)
  );

  aes_word_shift_reg #(.words_p(blk_words_lp), .width_p(word_width_p)) u_blk_sr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (blk_acc),
    .data_i  (data_i),
    .data_o  (ciphertext_o)
  );

  // A yumi with nothing offered is dropped by the FSM; flag it.
  yumi_legal_a: assert property (@(posedge clk_i) disable iff (!reset_i) yumi_i |-> v_o);

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Upstream input stage for the combinational `aes_decryption` core. It accepts a 32-bit word stream over a valid/ready handshake and assembles two registered outputs: a 256-bit AES key and a 128-bit ciphertext block. It presents them to the decryption core with a valid/yumi handshake and holds both stable until the consumer accepts the block. This gives the combinational datapath registered, stable operands and decouples a narrow bus from the 128/256-bit core.

## Interface
Parameters:
- `word_width_p`, default 32: input word width; must divide 128; fixed at 32 for this revision.

Ports:
- `clk_i`  in  1  single clock; all state changes on its rising edge.
- `reset_i`  in  1  reset, asynchronous and active-low.
- `data_i`  in  32  input word.
- `key_sel_i`  in  1  1 = word is a key word; 0 = word is a ciphertext word.
- `v_i`  in  1  `data_i`/`key_sel_i` valid.
- `ready_o`  out  1  word accepted on this cycle when `v_i & ready_o`.
- `key_o`  out  256  assembled key; feeds `initial_key` of the decryption core.
- `ciphertext_o`  out  128  assembled block; feeds `ciphertext` of the decryption core.
- `key_loaded_o`  out  1  all 8 key words of the current key have been received.
- `v_o`  out  1  block and key valid for the consumer.
- `yumi_i`  in  1  consumer takes the block this cycle; legal only while `v_o` = 1.

## Operation
- State machine states:
  - `eFILL`: collecting ciphertext words.
  - `eFULL`: a complete block is held.
- Key path:
  - 3-bit `key_cnt` counts key words.
  - Each accepted key word shifts into a 256-bit shift register: `key_r <= {key_r[223:0], data_i}`. The first word ends up in `key_o[255:224]`.
  - Accepting a key word while `key_cnt == 0` clears `key_loaded_o`.
  - Accepting the word at `key_cnt == 7` sets `key_loaded_o`, and `key_cnt` wraps to 0.
- Block path:
  - 2-bit `blk_cnt` counts ciphertext words.
  - Words shift into `ciphertext_o` the same way as the key path, so the first word lands in `[127:96]`.
  - Accepting the word at `blk_cnt == 3` moves the FSM `eFILL` -> `eFULL`, and `blk_cnt` wraps to 0.
- Key and ciphertext words may interleave freely; the two counters are independent.
- Ready rule: `ready_o = eFILL | (eFULL & ~key_loaded_o & key_sel_i)`.
  - In `eFULL`, key words are accepted only when no complete key is present. This lets a block that arrives before its key complete without deadlock.
  - `ready_o` depends combinationally on state and `key_sel_i` only, never on `v_i`.
- Output valid: `v_o = eFULL & key_loaded_o`.
- Consumption: `yumi_i & v_o` moves `eFULL` -> `eFILL`. `key_o` and `key_loaded_o` persist across blocks.
- Illegal handshake: `yumi_i` while `v_o` = 0 is ignored (flag with an assertion).
- Reset values: state `eFILL`, both counters 0, `key_o` = 0, `ciphertext_o` = 0, `key_loaded_o` = 0, `v_o` = 0.
- `ready_o` is forced to 0 while `reset_i` = 0.
- Reset mid-operation discards any partial key or block immediately, without waiting for a clock edge.

## Timing
- Last (4th) ciphertext word accepted at edge N: `v_o` = 1 from N+1, provided the key is loaded.
- If the key completes after the block: `v_o` rises the cycle after the 8th key word is accepted.
- `yumi_i` at edge M: `v_o` = 0 and `ready_o` = 1 from M+1.
- No word is accepted in the `yumi_i` cycle.
- Sustained rate: 5 cycles per block at one word per cycle.
- `key_o` and `ciphertext_o` are stable, with no glitches, throughout `v_o` = 1. The combinational decryption result is therefore valid the whole time.

## Structure
- `aes_pkg`: holds
  - the `key_words_lp` = 8 and `blk_words_lp` = 4 constants;
  - the `loader_state_e` enum `{eFILL, eFULL}`.
- Sub-module `aes_word_shift_reg #(words_p)`:
  - behaviour: async-low-reset shift register with enable;
  - instances: instantiated twice, once for the key and once for the block.

## Test plan
Vectors use the FIPS-197 C.3 AES-256 example.
- **Reset:** assert `reset_i` = 0 → all outputs 0 and `ready_o` = 0. Release → `ready_o` = 1 and `v_o` = 0.
- **Normal load:**
  - Stimulus: key words 00010203…1c1d1e1f, then ciphertext words 8ea2b7ca, 516745bf, eafc4990, 4b496089.
  - Response: `v_o` = 1 the cycle after the last word; `ciphertext_o` = 8ea2b7ca516745bfeafc49904b496089; `key_o` = 000102…1f.
  - Downstream decryption gives plaintext 00112233445566778899aabbccddeeff.
- **Backpressure:** hold `yumi_i` = 0 for 10 cycles after `v_o` → outputs remain stable and the next ciphertext word sees `ready_o` = 0. After `yumi_i`, that word is accepted the following cycle.
- **Block before key:** 4 ciphertext words with no key → `eFULL` with `v_o` = 0 and key words still accepted. `v_o` = 1 the cycle after the 8th key word.
- **Reset mid-fill:** 2 ciphertext words, then `reset_i` pulsed low → the next 4 words alone form `ciphertext_o`.
- **Key reload:** after one block is consumed, send 3 key words → `key_loaded_o` = 0. A following complete block holds `v_o` = 0 until all 8 key words have arrived.
